xof_stream_buffer: RTL and testbench
====================================

# xof_stream_buffer

Upstream feeder for the `parse` rejection sampler in the Kyber-768-90s datapath. It drives an external AES-256-CTR core one 128-bit counter block at a time and collects the returned keystream blocks. It unpacks them into the 768-word byte buffer that `parse` consumes as its input array `B`, then issues the one-cycle start pulse to `parse`. One instance serves each matrix entry A[i][j]; the nonce selects the entry.

## Interface
Parameters:
- NBLOCKS, 48: keystream blocks per fill (48 × 16 = 768 bytes).
- OUT_W, 10: width of each buffer word; bytes are zero-extended into it.

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  fill request; sampled only in IDLE or DONE
- nonce  in  96  CTR nonce (i‖j‖zero pad), captured at accepted start
- aes_req_valid  out  1  counter block valid
- aes_req_ready  in  1  AES core accepts counter block
- aes_ctr_block  out  128  {nonce, ctr[31:0]}, ctr big-endian in bits [31:0]
- aes_rsp_valid  in  1  keystream block valid; single-cycle, no backpressure
- aes_rsp_data  in  128  keystream block
- B  out  [0:NBLOCKS*16-1][OUT_W-1:0]  byte buffer to `parse`
- parse_start  out  1  one-cycle pulse when buffer complete
- busy  out  1  fill in progress (REQ or WAIT)
- done  out  1  level; buffer valid, held until next accepted start
- clear  in  1  present only with XOF_BUF_ZEROIZE_EN

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE/DONE, start=1: capture nonce, ctr←0, done←0, go to REQ. The buffer is not cleared.
- REQ: aes_req_valid=1, aes_ctr_block={nonce_q, ctr}. On valid&ready go to WAIT. Hold valid and data stable until accepted.
- WAIT: on aes_rsp_valid, write byte k of the block (byte 0 = data[127:120], byte 15 = data[7:0]) to B[16·ctr+k], zero-extended to OUT_W.
  - If ctr==NBLOCKS-1: go to DONE and pulse parse_start.
  - Otherwise: ctr←ctr+1 and go to REQ.
- One request outstanding at most. aes_rsp_valid in IDLE, REQ or DONE is ignored.
- start while busy is ignored.
- ctr is a 6-bit count 0..NBLOCKS-1, zero-extended to 32 bits on the bus. There is no wrap within a fill.
- Reset mid-fill: return to IDLE immediately. An AES response arriving afterwards is ignored.

## Timing
- Reset values: aes_req_valid=0, aes_ctr_block=0, parse_start=0, busy=0, done=0, every B word=0, state=IDLE.
- start high at edge t gives aes_req_valid=1 and busy=1 after edge t.
- A response sampled at edge r puts the buffer write at edge r. aes_req_valid for the next block rises after edge r.
- Minimum 2 cycles per block with ready=1 and zero AES latency, so the minimum fill is 96 cycles.
- Last response at edge r: done=1 and parse_start=1 after edge r, busy=0 after edge r, parse_start=0 after edge r+1.
- B is stable whenever done=1.

## Configuration
- XOF_BUF_ZEROIZE_EN defined:
  - The clear input exists.
  - clear=1 in IDLE or DONE zeroes all of B and drops done at the next edge; state becomes IDLE.
  - clear has priority over a simultaneous start.
  - clear is ignored while busy.
- Not defined: no clear port. B keeps its contents until overwritten.

## Structure
- Package xof_pkg: NBLOCKS_DEFAULT=48, BYTES_PER_BLOCK=16, CTR_W=6, NONCE_W=96, and the state enum xof_state_t {IDLE, REQ, WAIT, DONE}.
- No sub-module. FSM, counter and byte unpack (a generate loop over 16 byte lanes with a block-index write enable) all live in one module.

## Test plan
- Fill with ready=1, 3-cycle AES latency, keystream block n = 16 bytes all equal to n. Required:
  - B[0..15]=0, B[752..767]=47.
  - Exactly one parse_start, at cycle 1+48·5.
  - done=1.
- Counter sequence, nonce=0x000102…0B: the 48 accepted aes_ctr_block values are {nonce, 32'd0} … {nonce, 32'd47}, strictly in order.
- Backpressure: hold aes_req_ready=0 for 7 cycles in block 5. Required: valid and ctr stay 5 until accepted, and the final B is identical to the no-stall run.
- Spurious response and busy start: aes_rsp_valid=1 while in REQ, and start=1 while in WAIT. Both have no effect; B and ctr are unchanged.
- Reset after block 20 is written. Required:
  - All B=0, done=0, busy=0.
  - A late response is ignored.
  - A new start fills normally from ctr=0.
- With XOF_BUF_ZEROIZE_EN: clear=1 in DONE gives all B=0 and done=0 next cycle. clear and start together give IDLE with no request issued.

Source files
------------

// File: rtl/xof_stream_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : xof_pkg
// Desc     : Shared constants and the fill-FSM state type for the XOF
//            keystream buffer that feeds the parse rejection sampler.
// Revision : 1.0
// ============================================================================
package xof_pkg;

  localparam int NBLOCKS_DEFAULT = 48;  // 48 x 16 = 768 bytes per fill
  localparam int BYTES_PER_BLOCK = 16;  // one AES block
  localparam int CTR_W           = 6;   // block counter 0..NBLOCKS-1
  localparam int NONCE_W         = 96;  // i || j || zero pad

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } xof_state_t;

endpackage
`default_nettype wire

// File: rtl/xof_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module   : xof_stream_buffer
// Desc     : Issues AES-256-CTR counter blocks {nonce, ctr} one at a time,
//            unpacks each returned keystream block into the byte buffer B
//            (byte 0 = data[127:120]) and pulses parse_start once B is full.
// Options  : XOF_BUF_ZEROIZE_EN adds the clear input, which zeroes B and
//            drops done while the buffer is idle or complete.
// Revision : 1.0
// ============================================================================
module xof_stream_buffer
  import xof_pkg::*;
#(
  parameter int NBLOCKS = NBLOCKS_DEFAULT,
  parameter int OUT_W   = 10
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic [NONCE_W-1:0]                            nonce,
  output logic                                          aes_req_valid,
  input  logic                                          aes_req_ready,
  output logic [127:0]                                  aes_ctr_block,
  input  logic                                          aes_rsp_valid,
  input  logic [127:0]                                  aes_rsp_data,
  output logic [0:NBLOCKS*BYTES_PER_BLOCK-1][OUT_W-1:0] B,
  output logic                                          parse_start,
  output logic                                          busy,
  output logic                                          done
`ifdef XOF_BUF_ZEROIZE_EN
  ,
  input  logic                                          clear
`endif
);

  localparam logic [CTR_W-1:0] LAST_CTR = CTR_W'(NBLOCKS - 1);

  xof_state_t          state_q, state_d;
  logic [CTR_W-1:0]    ctr_q, ctr_d;
  logic [NONCE_W-1:0]  nonce_q, nonce_d;
  logic                done_q, done_d;
  logic                pstart_q, pstart_d;
  logic                blk_we;     // current WAIT response is written this cycle
  logic                zero_all;   // zeroise every buffer word this cycle
  logic                clear_req;
  logic [NBLOCKS-1:0]  blk_sel;    // one-hot block-index write enable

`ifdef XOF_BUF_ZEROIZE_EN
  assign clear_req = clear;
`else
  assign clear_req = 1'b0;
`endif

  // State, block counter, captured nonce and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ctr_q    <= '0;
      nonce_q  <= '0;
      done_q   <= 1'b0;
      pstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      nonce_q  <= nonce_d;
      done_q   <= done_d;
      pstart_q <= pstart_d;
    end
  end

  // Fill sequencing: one request outstanding, responses only honoured in WAIT
  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    nonce_d  = nonce_q;
    done_d   = done_q;
    pstart_d = 1'b0;
    blk_we   = 1'b0;
    zero_all = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        // clear wins over a simultaneous start; the buffer is not cleared by start
        if (clear_req) begin
          zero_all = 1'b1;
          done_d   = 1'b0;
          state_d  = IDLE;
        end else if (start) begin
          nonce_d = nonce;
          ctr_d   = '0;
          done_d  = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (aes_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (aes_rsp_valid) begin
          blk_we = 1'b1;
          if (ctr_q == LAST_CTR) begin
            state_d  = DONE;
            done_d   = 1'b1;
            pstart_d = 1'b1;
          end else begin
            ctr_d   = ctr_q + 1'b1;
            state_d = REQ;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign aes_req_valid = (state_q == REQ);
  // Counter block is only driven while a request is presented; zero otherwise
  assign aes_ctr_block = aes_req_valid ? {nonce_q, {(32-CTR_W){1'b0}}, ctr_q} : '0;
  assign busy          = (state_q == REQ) || (state_q == WAIT);
  assign done          = done_q;
  assign parse_start   = pstart_q;

  for (genvar n = 0; n < NBLOCKS; n++) begin : g_blk_sel
    assign blk_sel[n] = blk_we && (ctr_q == CTR_W'(n));
  end

  for (genvar k = 0; k < BYTES_PER_BLOCK; k++) begin : g_lane
    logic [OUT_W-1:0] lane_byte;
    assign lane_byte = OUT_W'(aes_rsp_data[127-8*k -: 8]);

    for (genvar n = 0; n < NBLOCKS; n++) begin : g_word
      logic [OUT_W-1:0] word_q;

      // One buffer word: zeroed by reset/clear, loaded when block n arrives
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          word_q <= '0;
        end else if (zero_all) begin
          word_q <= '0;
        end else if (blk_sel[n]) begin
          word_q <= lane_byte;
        end
      end

      assign B[n*BYTES_PER_BLOCK + k] = word_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xof_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_xof_stream_buffer
// Desc     : Directed self-checking bench for xof_stream_buffer with a
//            behavioural AES responder (configurable latency and stall).
// Revision : 1.0
// ============================================================================
module tb_xof_stream_buffer;

  localparam int NB = 48;
  localparam int NW = NB * 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [95:0]       nonce;
  logic              aes_req_valid;
  logic              aes_req_ready;
  logic [127:0]      aes_ctr_block;
  logic              aes_rsp_valid;
  logic [127:0]      aes_rsp_data;
  logic [0:NW-1][9:0] B;
  logic              parse_start;
  logic              busy;
  logic              done;
`ifdef XOF_BUF_ZEROIZE_EN
  logic              clear;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Responder controls (auto) and manual overrides
  logic         auto_en;
  logic         a_ready, a_rsp_valid;
  logic [127:0] a_rsp_data;
  logic         m_ready, m_rsp_valid;
  logic [127:0] m_rsp_data;
  int           lat, pat, stall_blk, stall_left;
  int           rsp_idx, cnt, acc_n;
  logic [127:0] acc_blk [0:63];

  assign aes_req_ready = auto_en ? a_ready     : m_ready;
  assign aes_rsp_valid = auto_en ? a_rsp_valid : m_rsp_valid;
  assign aes_rsp_data  = auto_en ? a_rsp_data  : m_rsp_data;

  xof_stream_buffer #(.NBLOCKS(NB), .OUT_W(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .nonce         (nonce),
    .aes_req_valid (aes_req_valid),
    .aes_req_ready (aes_req_ready),
    .aes_ctr_block (aes_ctr_block),
    .aes_rsp_valid (aes_rsp_valid),
    .aes_rsp_data  (aes_rsp_data),
    .B             (B),
    .parse_start   (parse_start),
    .busy          (busy),
    .done          (done)
`ifdef XOF_BUF_ZEROIZE_EN
    ,
    .clear         (clear)
`endif
  );

  always #5 clk = ~clk;

  // Keystream block n: pattern 0 = all bytes n, pattern 1 = byte k is (16n+k) mod 256
  function automatic logic [127:0] make_block(input int n, input int p);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = (p == 0) ? 8'(n) : 8'(16*n + k);
    return r;
  endfunction

  function automatic logic [9:0] exp_byte(input int i, input int p);
    return (p == 0) ? 10'(i / 16) : 10'(i % 256);
  endfunction

  // AES responder: decides ready on the falling edge, answers lat cycles after accept
  initial begin
    a_ready = 1'b1; a_rsp_valid = 1'b0; a_rsp_data = '0;
    cnt = 0; rsp_idx = 0; acc_n = 0;
    forever begin
      @(negedge clk);
      a_rsp_valid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          a_rsp_valid = 1'b1;
          a_rsp_data  = make_block(rsp_idx, pat);
          rsp_idx++;
        end
      end
      if (auto_en && aes_req_valid && aes_ctr_block[31:0] == 32'(stall_blk) && stall_left > 0) begin
        a_ready = 1'b0;
        stall_left--;
      end else begin
        a_ready = 1'b1;
      end
      if (auto_en && aes_req_valid && a_ready) begin
        if (acc_n < 64) acc_blk[acc_n] = aes_ctr_block;
        acc_n++;
        cnt = lat + 1;
      end
    end
  end

  // Launch a fill and watch it; edge 1 is the edge that samples start
  task automatic run_fill(input logic [95:0] nc, input int l, input int p, input int sblk,
                          input int scyc, output int ps_cnt, output int ps_edge, output bit tmo);
    int edge_n;
    @(negedge clk); #1;
    lat = l; pat = p; stall_blk = sblk; stall_left = scyc;
    rsp_idx = 0; acc_n = 0; cnt = 0; auto_en = 1'b1;
    nonce = nc; start = 1'b1;
    ps_cnt = 0; ps_edge = -1; tmo = 1'b0;
    @(posedge clk); edge_n = 1;
    forever begin
      @(negedge clk);
      start = 1'b0;
      if (parse_start) begin ps_cnt++; ps_edge = edge_n; end
      if (done) break;
      if (edge_n >= 3000) begin tmo = 1'b1; break; end
      @(posedge clk); edge_n++;
    end
    repeat (4) begin
      @(negedge clk);
      if (parse_start) ps_cnt++;
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (aes_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid got %b expected 0", aes_req_valid); end
    vectors++; if (aes_ctr_block !== 128'd0) begin miscompares++; $display("FAIL reset_ctr_block got %h expected 0", aes_ctr_block); end
    vectors++; if (parse_start !== 1'b0) begin miscompares++; $display("FAIL reset_parse_start got %b expected 0", parse_start); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b expected 0", done); end
    bad = -1;
    for (int i = 0; i < NW; i++) if (B[i] !== 10'd0 && bad < 0) bad = i;
    vectors++; if (bad >= 0) begin miscompares++; $display("FAIL reset_B idx %0d got %h expected 0", bad, B[bad]); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (busy !== 1'b0 || aes_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_idle busy %b valid %b expected 0 0", busy, aes_req_valid); end
  endtask

  task automatic test_fill_equal();
    int ps_cnt, ps_edge, bad; bit tmo;
    run_fill(96'h0A0B0C0D0E0F101112131415, 3, 0, -1, 0, ps_cnt, ps_edge, tmo);
    vectors++; if (tmo) begin miscompares++; $display("FAIL fill_timeout got timeout expected done"); end
    vectors++; if (ps_cnt != 1) begin miscompares++; $display("FAIL fill_ps_count got %0d expected 1", ps_cnt); end
    vectors++; if (ps_edge != 1 + 48*5) begin miscompares++; $display("FAIL fill_ps_cycle got %0d expected %0d", ps_edge, 1 + 48*5); end
    vectors++; if (done !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL fill_status done %b busy %b expected 1 0", done, busy); end
    vectors++; if (acc_n != 48) begin miscompares++; $display("FAIL fill_req_count got %0d expected 48", acc_n); end
    bad = -1;
    for (int i = 0; i < 16; i++) if (B[i] !== 10'd0 && bad < 0) bad = i;
    vectors++; if (bad >= 0) begin miscompares++; $display("FAIL fill_B_first idx %0d got %h expected 0", bad, B[bad]); end
    bad = -1;
    for (int i = 752; i < NW; i++) if (B[i] !== 10'd47 && bad < 0) bad = i;
    vectors++; if (bad >= 0) begin miscompares++; $display("FAIL fill_B_last idx %0d got %h expected 2f", bad, B[bad]); end
    bad = -1;
    for (int i = 0; i < NW; i++) if (B[i] !== exp_byte(i, 0) && bad < 0) bad = i;
    vectors++; if (bad >= 0) begin miscompares++; $display("FAIL fill_B_all idx %0d got %h expected %h", bad, B[bad], exp_byte(bad, 0)); end
  endtask

  task automatic test_counter_seq();
    int ps_cnt, ps_edge, bad; bit tmo;
    logic [95:0] nc;
    nc = 96'h000102030405060708090A0B;
    run_fill(nc, 0, 1, -1, 0, ps_cnt, ps_edge, tmo);
    vectors++; if (tmo || acc_n != 48) begin miscompares++; $display("FAIL ctr_req_count got %0d expected 48", acc_n); end
    bad = -1;
    for (int i = 0; i < 48; i++) if (acc_blk[i] !== {nc, 32'(i)} && bad < 0) bad = i;
    vectors++; if (bad >= 0) begin miscompares++; $display("FAIL ctr_seq idx %0d got %h expected %h", bad, acc_blk[bad], {nc, 32'(bad)}); end
    vectors++; if (ps_edge != 1 + 48*2 || ps_cnt != 1) begin miscompares++; $display("FAIL ctr_ps_cycle got %0d/%0d expected %0d/1", ps_edge, ps_cnt, 1 + 48*2); end
    bad = -1;
    for (int i = 0; i < NW; i++) if (B[i] !== exp_byte(i, 1) && bad < 0) bad = i;
    vectors++; if (bad >= 0) begin miscompares++; $display("FAIL ctr_B_all idx %0d got %h expected %h", bad, B[bad], exp_byte(bad, 1)); end
  endtask

  task automatic test_spurious_busy_start();
    int bad;
    logic [95:0]  n2;
    logic [127:0] d;
    n2 = 96'hA5A5_0000_1111_2222_3333_4444;
    d  = 128'h112233445566778899AABBCCDDEEFF00;
    @(negedge clk); #1;
    auto_en = 1'b0; m_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_data = '0;
    nonce = n2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    vectors++; if (aes_req_valid !== 1'b1 || aes_ctr_block !== {n2, 32'd0}) begin miscompares++; $display("FAIL spur_req got %b %h expected 1 %h", aes_req_valid, aes_ctr_block, {n2, 32'd0}); end
    m_rsp_valid = 1'b1; m_rsp_data = {16{8'hEE}};
    @(negedge clk); m_rsp_valid = 1'b0;
    vectors++; if (aes_req_valid !== 1'b1 || aes_ctr_block !== {n2, 32'd0}) begin miscompares++; $display("FAIL spur_rsp_in_req got %b %h expected 1 %h", aes_req_valid, aes_ctr_block, {n2, 32'd0}); end
    bad = -1;
    for (int i = 0; i < 16; i++) if (B[i] !== 10'(i) && bad < 0) bad = i;
    vectors++; if (bad >= 0) begin miscompares++; $display("FAIL spur_B_kept idx %0d got %h expected %h", bad, B[bad], 10'(bad)); end
    m_ready = 1'b1;
    @(negedge clk); m_ready = 1'b0;
    vectors++; if (busy !== 1'b1 || aes_req_valid !== 1'b0) begin miscompares++; $display("FAIL spur_wait busy %b valid %b expected 1 0", busy, aes_req_valid); end
    nonce = 96'hDEAD; start = 1'b1;
    @(negedge clk); start = 1'b0;
    vectors++; if (busy !== 1'b1 || aes_req_valid !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL busy_start busy %b valid %b done %b expected 1 0 0", busy, aes_req_valid, done); end
    m_rsp_valid = 1'b1; m_rsp_data = d;
    @(negedge clk); m_rsp_valid = 1'b0;
    vectors++; if (aes_req_valid !== 1'b1 || aes_ctr_block !== {n2, 32'd1}) begin miscompares++; $display("FAIL spur_next_req got %b %h expected 1 %h", aes_req_valid, aes_ctr_block, {n2, 32'd1}); end
    bad = -1;
    for (int i = 0; i < 32; i++) begin
      if (i < 16) begin
        if (B[i] !== 10'(d[127-8*i -: 8]) && bad < 0) bad = i;
      end else begin
        if (B[i] !== 10'(i) && bad < 0) bad = i;
      end
    end
    vectors++; if (bad >= 0) begin miscompares++; $display("FAIL spur_B_write idx %0d got %h", bad, B[bad]); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    auto_en = 1'b1;
  endtask

  task automatic test_backpressure();
    int ps_cnt, ps_edge, bad; bit tmo;
    logic [95:0] nc;
    nc = 96'h1234_5678_9ABC_DEF0_0F1E_2D3C;
    run_fill(nc, 0, 1, 5, 7, ps_cnt, ps_edge, tmo);
    vectors++; if (tmo || acc_n != 48) begin miscompares++; $display("FAIL bp_req_count got %0d expected 48", acc_n); end
    bad = -1;
    for (int i = 0; i < 48; i++) if (acc_blk[i] !== {nc, 32'(i)} && bad < 0) bad = i;
    vectors++; if (bad >= 0) begin miscompares++; $display("FAIL bp_seq idx %0d got %h expected %h", bad, acc_blk[bad], {nc, 32'(bad)}); end
    vectors++; if (ps_edge != 1 + 48*2 + 7 || ps_cnt != 1) begin miscompares++; $display("FAIL bp_ps_cycle got %0d/%0d expected %0d/1", ps_edge, ps_cnt, 1 + 48*2 + 7); end
    bad = -1;
    for (int i = 0; i < NW; i++) if (B[i] !== exp_byte(i, 1) && bad < 0) bad = i;
    vectors++; if (bad >= 0) begin miscompares++; $display("FAIL bp_B_all idx %0d got %h expected %h", bad, B[bad], exp_byte(bad, 1)); end
  endtask

  task automatic test_reset_midfill();
    int ps_cnt, ps_edge, bad, guard; bit tmo;
    logic [95:0] nc;
    nc = 96'hFEED_FACE_0102_0304_0506_0708;
    @(negedge clk); #1;
    lat = 3; pat = 1; stall_blk = -1; stall_left = 0;
    rsp_idx = 0; acc_n = 0; cnt = 0; auto_en = 1'b1;
    nonce = nc; start = 1'b1;
    @(negedge clk); start = 1'b0;
    guard = 0;
    while (rsp_idx < 21 && guard < 2000) begin @(negedge clk); #1; guard++; end
    vectors++; if (rsp_idx < 21) begin miscompares++; $display("FAIL mid_timeout got %0d responses expected 21", rsp_idx); end
    @(negedge clk); #2;
    vectors++; if (B[320] !== 10'd64 || B[335] !== 10'd79) begin miscompares++; $display("FAIL mid_blk20 got %h %h expected 040 04f", B[320], B[335]); end
    rst = 1'b1; #1;
    bad = -1;
    for (int i = 0; i < NW; i++) if (B[i] !== 10'd0 && bad < 0) bad = i;
    vectors++; if (bad >= 0) begin miscompares++; $display("FAIL mid_async_B idx %0d got %h expected 0", bad, B[bad]); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL mid_async_status busy %b done %b expected 0 0", busy, done); end
    @(negedge clk); rst = 1'b0;
    repeat (8) @(negedge clk);
    bad = -1;
    for (int i = 0; i < NW; i++) if (B[i] !== 10'd0 && bad < 0) bad = i;
    vectors++; if (bad >= 0) begin miscompares++; $display("FAIL mid_late_rsp_B idx %0d got %h expected 0", bad, B[bad]); end
    vectors++; if (busy !== 1'b0 || aes_req_valid !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL mid_late_status busy %b valid %b done %b expected 0 0 0", busy, aes_req_valid, done); end
    run_fill(nc, 0, 0, -1, 0, ps_cnt, ps_edge, tmo);
    vectors++; if (tmo || acc_n != 48 || acc_blk[0] !== {nc, 32'd0}) begin miscompares++; $display("FAIL mid_refill_first got %0d %h expected 48 %h", acc_n, acc_blk[0], {nc, 32'd0}); end
    vectors++; if (ps_edge != 1 + 48*2 || ps_cnt != 1) begin miscompares++; $display("FAIL mid_refill_cycle got %0d/%0d expected %0d/1", ps_edge, ps_cnt, 1 + 48*2); end
    bad = -1;
    for (int i = 0; i < NW; i++) if (B[i] !== exp_byte(i, 0) && bad < 0) bad = i;
    vectors++; if (bad >= 0) begin miscompares++; $display("FAIL mid_refill_B idx %0d got %h expected %h", bad, B[bad], exp_byte(bad, 0)); end
  endtask

`ifdef XOF_BUF_ZEROIZE_EN
  task automatic test_zeroize();
    int bad, acc_before;
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL zero_pre_done got %b expected 1", done); end
    @(negedge clk); #1; clear = 1'b1;
    @(negedge clk); #1; clear = 1'b0;
    bad = -1;
    for (int i = 0; i < NW; i++) if (B[i] !== 10'd0 && bad < 0) bad = i;
    vectors++; if (bad >= 0) begin miscompares++; $display("FAIL zero_B idx %0d got %h expected 0", bad, B[bad]); end
    vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL zero_status done %b busy %b expected 0 0", done, busy); end
    acc_before = acc_n;
    clear = 1'b1; start = 1'b1; nonce = 96'h77;
    @(negedge clk); #1; clear = 1'b0; start = 1'b0;
    vectors++; if (busy !== 1'b0 || aes_req_valid !== 1'b0) begin miscompares++; $display("FAIL zero_prio busy %b valid %b expected 0 0", busy, aes_req_valid); end
    repeat (3) @(negedge clk);
    vectors++; if (acc_n != acc_before) begin miscompares++; $display("FAIL zero_no_req got %0d requests expected %0d", acc_n, acc_before); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; nonce = '0;
    auto_en = 1'b1; m_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_data = '0;
    lat = 0; pat = 0; stall_blk = -1; stall_left = 0;
`ifdef XOF_BUF_ZEROIZE_EN
    clear = 1'b0;
`endif
    test_reset();
    test_fill_equal();
    test_counter_seq();
    test_spurious_busy_start();
    test_backpressure();
    test_reset_midfill();
`ifdef XOF_BUF_ZEROIZE_EN
    test_zeroize();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
